// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: (2N+1)-bit accumulator plus shift counter,
// sequenced by load/sh/ad from the multiplier control FSM.
module mult_datapath #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           sh,
  input  logic           ad,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic           m,
  output logic           k,
  output logic [2*N-1:0] product
);

  localparam int unsigned AW = 2 * N + 1;
  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [N:0]    sum;
  logic [CW-1:0] cnt_inc;

  // Upper-half add with the carry landing in the extra accumulator bit
  always_comb begin
    sum     = {1'b0, acc[2*N-1:N]} + {1'b0, mcand};
    cnt_inc = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= {(N + 1)'(0), mplier};
      cnt <= '0;
    end else if (ad && sh) begin
      // Add then shift in one cycle: the carry drops into the top of the upper half
      acc <= {1'b0, sum, acc[N-1:1]};
      cnt <= cnt_inc;
    end else if (ad) begin
      acc <= {sum, acc[N-1:0]};
    end else if (sh) begin
      acc <= {1'b0, acc[AW-1:1]};
      cnt <= cnt_inc;
    end
  end

  assign m       = acc[0];
  assign k       = (cnt == CNT_LAST);
  assign product = acc[2*N-1:0];

endmodule

// File: tb/tb_mult_datapath.sv
// Scoreboard bench for mult_datapath: a behavioural accumulator model predicts
// m/k/product per control cycle; spec walk-through values are checked too.
module tb_mult_datapath;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           load, sh, ad;
  logic [N-1:0]   mcand, mplier;
  logic           m, k;
  logic [2*N-1:0] product;

  mult_datapath #(.N(N)) dut (
    .clk(clk), .rst(rst), .load(load), .sh(sh), .ad(ad),
    .mcand(mcand), .mplier(mplier), .m(m), .k(k), .product(product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*N-1:0] product;
    logic           m;
    logic           k;
    string          tag;
  } exp_t;

  exp_t exp_q[$];

  logic [2*N:0] macc;
  int           mcnt;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    macc = '0;
    mcnt = 0;
  endtask

  // One control cycle, entered and left at the falling edge
  task automatic step(input logic l, input logic a, input logic s, input string tag);
    exp_t e;
    logic [N:0] s_up;
    load = l; ad = a; sh = s;
    s_up = (N + 1)'(macc[2*N-1:N]) + (N + 1)'(mcand);
    if (l) begin
      macc = {(N + 1)'(0), mplier};
      mcnt = 0;
    end else if (a && s) begin
      macc = {s_up, macc[N-1:0]} >> 1;
      mcnt = (mcnt + 1) % N;
    end else if (a) begin
      macc = {s_up, macc[N-1:0]};
    end else if (s) begin
      macc = macc >> 1;
      mcnt = (mcnt + 1) % N;
    end
    e.product = macc[2*N-1:0];
    e.m       = macc[0];
    e.k       = (mcnt == N - 1);
    e.tag     = tag;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; ad = 1'b0; sh = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, "/queue"}, 32'(0), 32'(1));
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "/product"}, 32'(product), 32'(e.product));
      check({e.tag, "/m"}, 32'(m), 32'(e.m));
      check({e.tag, "/k"}, 32'(k), 32'(e.k));
    end
  endtask

  // Full multiply with control decisions taken from the model's multiplier bit
  task automatic run_mult(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic combined, input string tag);
    mcand  = a;
    mplier = b;
    step(1'b1, 1'b0, 1'b0, {tag, "/load"});
    for (int i = 0; i < N; i++) begin
      if (macc[0]) begin
        if (combined) step(1'b0, 1'b1, 1'b1, {tag, "/adsh"});
        else begin
          step(1'b0, 1'b1, 1'b0, {tag, "/ad"});
          step(1'b0, 1'b0, 1'b1, {tag, "/sh"});
        end
      end else begin
        step(1'b0, 1'b0, 1'b1, {tag, "/sh"});
      end
    end
    check({tag, "/final"}, 32'(product), 32'(a) * 32'(b));
    check({tag, "/final_k"}, 32'(k), 32'(0));
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; sh = 1'b0; ad = 1'b0; mcand = '0; mplier = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset/product", 32'(product), 32'(0));
    check("reset/m", 32'(m), 32'(0));
    check("reset/k", 32'(k), 32'(0));
    rst = 1'b0;

    // 13x11 walk-through against hand-derived accumulator values
    mcand = 4'd13; mplier = 4'd11;
    step(1'b1, 1'b0, 1'b0, "w/load"); check("w/load_v", 32'(product), 32'(8'b0000_1011));
    step(1'b0, 1'b1, 1'b0, "w/ad1");  check("w/ad1_v", 32'(product), 32'(8'b1101_1011));
    step(1'b0, 1'b0, 1'b1, "w/sh1");  check("w/sh1_v", 32'(product), 32'(8'b0110_1101));
    step(1'b0, 1'b1, 1'b0, "w/ad2");  check("w/ad2_v", 32'(product), 32'(8'b0011_1101));
    step(1'b0, 1'b0, 1'b1, "w/sh2");  check("w/sh2_v", 32'(product), 32'(8'b1001_1110));
    check("w/sh2_m", 32'(m), 32'(0));
    step(1'b0, 1'b0, 1'b1, "w/sh3");  check("w/sh3_v", 32'(product), 32'(8'b0100_1111));
    check("w/sh3_k", 32'(k), 32'(1));
    step(1'b0, 1'b1, 1'b0, "w/ad3");  check("w/ad3_v", 32'(product), 32'(8'b0001_1111));
    step(1'b0, 1'b0, 1'b1, "w/sh4");  check("w/sh4_v", 32'(product), 32'(143));
    check("w/sh4_k", 32'(k), 32'(0));

    run_mult(4'd13, 4'd11, 1'b1, "comb13x11");
    run_mult(4'd15, 4'd15, 1'b0, "15x15");
    run_mult(4'd15, 4'd15, 1'b1, "15x15c");
    run_mult(4'd0,  4'd15, 1'b0, "0x15");
    run_mult(4'd15, 4'd0,  1'b0, "15x0");
    run_mult(4'd9,  4'd6,  1'b1, "9x6");

    // Load wins over simultaneous add and shift
    mcand = 4'd13; mplier = 4'd5;
    step(1'b1, 1'b1, 1'b1, "prio");
    check("prio/v", 32'(product), 32'(5));
    // Counter restarted by the priority load: k rises only on the third shift
    step(1'b0, 1'b0, 1'b1, "kt/sh1"); check("kt/k1", 32'(k), 32'(0));
    step(1'b0, 1'b0, 1'b1, "kt/sh2"); check("kt/k2", 32'(k), 32'(0));
    step(1'b0, 1'b0, 1'b1, "kt/sh3"); check("kt/k3", 32'(k), 32'(1));
    step(1'b0, 1'b0, 1'b1, "kt/sh4"); check("kt/k4", 32'(k), 32'(0));

    // Asynchronous reset in the middle of a multiply, between clock edges
    mcand = 4'd13; mplier = 4'd11;
    step(1'b1, 1'b0, 1'b0, "r/load");
    step(1'b0, 1'b1, 1'b0, "r/ad1");
    step(1'b0, 1'b0, 1'b1, "r/sh1");
    step(1'b0, 1'b0, 1'b1, "r/sh2");
    check("r/pre_nonzero", 32'(product != '0), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("r/async_product", 32'(product), 32'(0));
    check("r/async_m", 32'(m), 32'(0));
    check("r/async_k", 32'(k), 32'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, "r/hold");
    step(1'b0, 1'b0, 1'b1, "r/sh_after");
    step(1'b0, 1'b0, 1'b1, "r/sh_after2");
    step(1'b0, 1'b0, 1'b1, "r/sh_after3");
    check("r/cnt_zeroed_k", 32'(k), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
